// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product stream, the accumulator and its result consumer.
// The master side drives products and consumes sums; the slave side is the accumulator.
interface product_accumulator_if #(
  parameter int ACC_W = 12
) ();
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN unsigned 8-bit products per block and holds the result with a
// sticky overflow flag until the consumer takes it.
module product_accumulator #(
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  product_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // One spare bit on top of the accumulator captures the carry out.
  logic [ACC_W:0]   sum_ext;
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.in_data};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ACC: begin
        if (bus.in_valid) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          if (start) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come only from registers and the state decode.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default-sized instance plus an
// 8-bit, two-product instance for the overflow case.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a;
  logic busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(12)) bus_a ();
  product_accumulator_if #(.ACC_W(8))  bus_b ();

  product_accumulator #(.BLOCK_LEN(4), .ACC_W(12)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .busy  (busy_a),
    .bus   (bus_a.slave)
  );

  product_accumulator #(.BLOCK_LEN(2), .ACC_W(8)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .busy  (busy_b),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer_a(input logic v, input logic [7:0] d);
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    step();
  endtask

  task automatic check_a(input string tag, input logic busy, input logic rdy,
                         input logic vld, input logic [31:0] sum, input logic ovf);
    check({tag, ".busy"},      32'(busy_a),          32'(busy));
    check({tag, ".in_ready"},  32'(bus_a.in_ready),  32'(rdy));
    check({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(vld));
    check({tag, ".out_sum"},   32'(bus_a.out_sum),   sum);
    check({tag, ".out_ovf"},   32'(bus_a.out_ovf),   32'(ovf));
  endtask

  initial begin
    logic       pat_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] pat_d [7] = '{8'd1, 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd4};

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check_a("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Four products of 225 -> 900, no overflow
    start_a = 1'b1; step(); start_a = 1'b0;
    check_a("max.enter", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) xfer_a(1'b1, 8'd225);
    check_a("max.partial", 1'b1, 1'b1, 1'b0, 32'd675, 1'b0);
    xfer_a(1'b1, 8'd225);
    bus_a.in_valid = 1'b0;
    check_a("max.hold", 1'b1, 1'b0, 1'b1, 32'd900, 1'b0);
    bus_a.out_ready = 1'b1; step(); bus_a.out_ready = 1'b0;
    check_a("max.idle", 1'b0, 1'b0, 1'b0, 32'd900, 1'b0);

    // Gapped valid stream, then a stalled consumer
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 7; i++) xfer_a(pat_v[i], pat_d[i]);
    bus_a.in_valid = 1'b0;
    check_a("gap.hold", 1'b1, 1'b0, 1'b1, 32'd10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check(
        $sformatf("gap.stall%0d.out_valid", i), 32'(bus_a.out_valid), 32'd1);
      check($sformatf("gap.stall%0d.out_sum", i), 32'(bus_a.out_sum), 32'd10);
    end
    bus_a.out_ready = 1'b1; step(); bus_a.out_ready = 1'b0;
    check_a("gap.idle", 1'b0, 1'b0, 1'b0, 32'd10, 1'b0);

    // Data presented with start in IDLE is not accumulated
    start_a = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = 8'd99;
    step(); start_a = 1'b0;
    check_a("idle_data.enter", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) xfer_a(1'b1, 8'(5 + i));
    bus_a.in_valid = 1'b0;
    check_a("idle_data.hold", 1'b1, 1'b0, 1'b1, 32'd26, 1'b0);

    // Back-to-back: consume and restart on the same edge
    bus_a.out_ready = 1'b1; start_a = 1'b1; step();
    bus_a.out_ready = 1'b0; start_a = 1'b0;
    check_a("b2b.enter", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) xfer_a(1'b1, 8'(10 * (i + 1)));
    bus_a.in_valid = 1'b0;
    check_a("b2b.hold", 1'b1, 1'b0, 1'b1, 32'd100, 1'b0);
    start_a = 1'b1; step(); start_a = 1'b0;
    check_a("b2b.start_no_ready", 1'b1, 1'b0, 1'b1, 32'd100, 1'b0);
    bus_a.out_ready = 1'b1; step(); bus_a.out_ready = 1'b0;
    check_a("b2b.idle", 1'b0, 1'b0, 1'b0, 32'd100, 1'b0);

    // Mid-block reset discards the partial sum
    start_a = 1'b1; step(); start_a = 1'b0;
    xfer_a(1'b1, 8'd20);
    xfer_a(1'b1, 8'd30);
    bus_a.in_valid = 1'b0;
    check_a("rst.partial", 1'b1, 1'b1, 1'b0, 32'd50, 1'b0);
    start_a = 1'b1; step(); start_a = 1'b0;
    check_a("rst.start_in_acc", 1'b1, 1'b1, 1'b0, 32'd50, 1'b0);
    rst = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_data = 8'd7;
    step(); rst = 1'b0;
    check_a("rst.after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) xfer_a(1'b1, 8'd9);
    bus_a.in_valid = 1'b0;
    check_a("rst.no_start", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // ACC_W=8, BLOCK_LEN=2: 200+200 wraps to 144 with overflow
    start_b = 1'b1; step(); start_b = 1'b0;
    check("ovf.enter.busy", 32'(busy_b), 32'd1);
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'd200; step();
    check("ovf.first.out_sum", 32'(bus_b.out_sum), 32'd200);
    check("ovf.first.out_ovf", 32'(bus_b.out_ovf), 32'd0);
    step(); bus_b.in_valid = 1'b0;
    check("ovf.hold.out_valid", 32'(bus_b.out_valid), 32'd1);
    check("ovf.hold.out_sum", 32'(bus_b.out_sum), 32'd144);
    check("ovf.hold.out_ovf", 32'(bus_b.out_ovf), 32'd1);
    bus_b.out_ready = 1'b1; step(); bus_b.out_ready = 1'b0;
    check("ovf.idle.busy", 32'(busy_b), 32'd0);
    check("ovf.idle.out_ovf", 32'(bus_b.out_ovf), 32'd1);
    start_b = 1'b1; step(); start_b = 1'b0;
    check("ovf.restart.out_ovf", 32'(bus_b.out_ovf), 32'd0);
    check("ovf.restart.out_sum", 32'(bus_b.out_sum), 32'd0);
    check("ovf.restart.in_ready", 32'(bus_b.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: BLOCK_LEN, default 4, number of 8-bit products summed per block (legal 1..15).
REQ-002 Parameter: ACC_W, default 12, accumulator width in bits (legal 8..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  begin a new block; clears the accumulator.
REQ-006 in_valid  input  1  in_data carries a valid product from the upstream 4x4 array multiplier.
REQ-007 in_data  input  8  unsigned product, 0..225.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  out_sum and out_ovf hold a completed block result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_sum  output  ACC_W  accumulator value.
REQ-012 out_ovf  output  1  sticky overflow flag for the current or last block.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACC and HOLD; in_ready=1 only in ACC; out_valid=1 only in HOLD.
REQ-015 IDLE: start=1 SHALL move to ACC and clear acc, cnt and ovf to 0 on the same edge; in_valid is ignored.
REQ-016 ACC: a transfer occurs on an edge with in_valid=1 and in_ready=1; it SHALL set acc <= acc + zero-extended in_data modulo 2^ACC_W and cnt <= cnt+1.
REQ-017 A carry out of bit ACC_W-1 on any transfer SHALL set ovf=1; ovf stays set until the next start or rst.
REQ-018 A transfer with cnt==BLOCK_LEN-1 SHALL move to ACC->HOLD; out_valid SHALL rise in the cycle after that edge, with out_sum equal to the final sum.
REQ-019 ACC with in_valid=0 SHALL hold all state; there is no timeout.
REQ-020 HOLD: out_sum and out_ovf SHALL remain stable until out_ready=1; on that edge the FSM SHALL move to IDLE.
REQ-021 HOLD with out_ready=1 and start=1 on the same edge SHALL move directly to ACC, with acc, cnt and ovf cleared (back-to-back blocks).
REQ-022 start SHALL be ignored in ACC, and in HOLD when out_ready=0.
REQ-023 In IDLE, out_sum and out_ovf SHALL keep the last block's values.
REQ-024 cnt width SHALL be 4 bits; cnt is never observable.
REQ-025 All outputs SHALL be driven from registers or the state decode; there are no combinational paths from inputs to outputs.

Reset
REQ-026 rst=1 SHALL force on the next edge: state=IDLE, acc=0, cnt=0, ovf=0; therefore in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-027 rst SHALL take priority over start, transfers and out_ready, including mid-block and in HOLD; any partial sum is discarded.

Verification
REQ-028 Defaults; start, then in_data=225 (15x15) for 4 consecutive valid cycles -> out_valid one cycle after the 4th transfer, out_sum=900 (0x384), out_ovf=0.
REQ-029 ACC_W=8, BLOCK_LEN=2; products 200 and 200 -> out_sum=144, out_ovf=1; next start -> out_ovf=0.
REQ-030 Defaults; in_valid toggled 1,0,0,1,1,0,1 with data 1,2,3,4 on the valid cycles -> out_sum=10; out_ready held 0 for 5 cycles -> out_sum stays 10 and out_valid stays 1.
REQ-031 Defaults; after 2 transfers (sum 50), rst=1 for one cycle -> all outputs 0; in_valid pulses with no start -> no state change.
REQ-032 Defaults; in HOLD, out_ready=1 and start=1 on the same edge -> next cycle busy=1, in_ready=1, out_valid=0, and the new block sums from 0.
REQ-033 Defaults; start with in_valid=1 in IDLE -> that data is not accumulated; the first accepted transfer is in the cycle after entering ACC.
